// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg
//   Shared definitions for the digit-serial ALU:
//   - op encodings (OP_ADD .. OP_XOR); codes 101-111 are reserved and run as add
//   - FSM state enum (IDLE, RUN, DONE)
//   - small op-classification helpers used by the slice and the flag logic
package serial_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Logic ops never produce carry or overflow.
    function automatic logic is_logic_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
    endfunction

    // Only the exact sub code inverts b; reserved codes fall through to add.
    function automatic logic is_sub_op(input logic [2:0] op);
        return (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_if.sv
// serial_alu_if
//   Request/result bundle of the serial ALU.
//   master: drives start, op, i0, i1; observes busy, done, o, cout, ovf, zero
//   slave : the ALU side (mirror of master)
interface serial_alu_if #(
    parameter int WIDTH = 16
) ();

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] o;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, op, i0, i1,
        input  busy, done, o, cout, ovf, zero
    );

    modport slave (
        input  start, op, i0, i1,
        output busy, done, o, cout, ovf, zero
    );

endinterface

// File: rtl/serial_alu_digit.sv
// serial_alu_digit
//   Combinational DIGIT-bit arithmetic/logic slice.
//   a, b : operand digits        cin  : carry into the slice LSB
//   op   : operation code        r    : digit result
//   cout : carry out of slice MSB (0 for logic ops)
//   cmsb : carry into slice MSB, used for signed overflow (0 for logic ops)
module serial_alu_digit
    import serial_alu_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic [DIGIT-1:0] r,
    output logic             cout,
    output logic             cmsb
);

    logic [DIGIT-1:0] bx_s;
    logic [DIGIT-1:0] sum_s;
    logic [DIGIT:0]   c_s;

    // Ripple of full-adder cells; b is inverted for sub (cin supplies the +1).
    always_comb begin
        bx_s  = is_sub_op(op) ? ~b : b;
        sum_s = {DIGIT{1'b0}};
        c_s   = {(DIGIT + 1){1'b0}};
        c_s[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum_s[i]   = a[i] ^ bx_s[i] ^ c_s[i];
            c_s[i + 1] = (a[i] & bx_s[i]) | (c_s[i] & (a[i] ^ bx_s[i]));
        end
    end

    // Result mux; every code that is not a logic op takes the adder path.
    always_comb begin
        r    = sum_s;
        cout = c_s[DIGIT];
        cmsb = c_s[DIGIT-1];
        case (op)
            OP_AND: begin
                r    = a & b;
                cout = 1'b0;
                cmsb = 1'b0;
            end
            OP_OR: begin
                r    = a | b;
                cout = 1'b0;
                cmsb = 1'b0;
            end
            OP_XOR: begin
                r    = a ^ b;
                cout = 1'b0;
                cmsb = 1'b0;
            end
            OP_ADD, OP_SUB: begin
                r    = sum_s;
                cout = c_s[DIGIT];
                cmsb = c_s[DIGIT-1];
            end
            default: begin
                r    = sum_s;
                cout = c_s[DIGIT];
                cmsb = c_s[DIGIT-1];
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// serial_alu
//   Digit-serial ALU: operands are latched on an accepted start and processed
//   LSB-first, DIGIT bits per cycle, through one serial_alu_digit slice.
//   N = WIDTH/DIGIT digit cycles; done pulses one cycle after the last digit.
//   WIDTH must be a multiple of DIGIT.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : serial_alu_if slave (start/op/i0/i1 in; busy/done/o/cout/ovf/zero out)
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_alu_if.slave  bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 32'sd1) ? $clog2(N) : 32'sd1;
    localparam logic [CW-1:0] LAST = CW'(N - 32'sd1);
    localparam logic [CW-1:0] ONE  = CW'(1'b1);

    state_t           state_r;
    state_t           state_s;
    logic             accept_s;
    logic             last_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] acc_r;

    logic [DIGIT-1:0] dr_s;
    logic             dcout_s;
    logic             dcmsb_s;
    logic [WIDTH-1:0] acc_next_s;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] o_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    serial_alu_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_r[DIGIT-1:0]),
        .b    (b_r[DIGIT-1:0]),
        .cin  (carry_r),
        .op   (op_r),
        .r    (dr_s),
        .cout (dcout_s),
        .cmsb (dcmsb_s)
    );

    // New digit enters at the MSB end so that after N shifts digit 0 sits at bit 0.
    assign acc_next_s = (acc_r >> DIGIT) | (WIDTH'(dr_s) << (WIDTH - DIGIT));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; accept_s marks the loading edge, last_s the final digit.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST) begin
                    state_s = DONE;
                    last_s  = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry, digit counter and result accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            op_r    <= OP_ADD;
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            a_r     <= bus.i0;
            b_r     <= bus.i1;
            op_r    <= bus.op;
            carry_r <= is_sub_op(bus.op);
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
        end else if (state_r == RUN) begin
            a_r     <= a_r >> DIGIT;
            b_r     <= b_r >> DIGIT;
            carry_r <= dcout_s;
            cnt_r   <= cnt_r + ONE;
            acc_r   <= acc_next_s;
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
            acc_r   <= acc_r;
        end
    end

    // Status and result registers; o and flags only change on the final digit,
    // so no partial result is ever visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            o_r    <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            busy_r <= (state_s == RUN);
            done_r <= last_s;
            if (last_s) begin
                o_r    <= acc_next_s;
                cout_r <= ~is_logic_op(op_r) & dcout_s;
                ovf_r  <= ~is_logic_op(op_r) & (dcout_s ^ dcmsb_s);
                zero_r <= (acc_next_s == {WIDTH{1'b0}});
            end else begin
                o_r    <= o_r;
                cout_r <= cout_r;
                ovf_r  <= ovf_r;
                zero_r <= zero_r;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.o    = o_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
    assign bus.zero = zero_r;

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu
//   Self-checking bench: a bit-serial instance (DIGIT=1) and a DIGIT=4 instance,
//   driven with directed and $urandom operations and compared against a
//   plain-arithmetic reference model.
module tb_serial_alu;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    serial_alu_if #(.WIDTH(16)) bus  ();
    serial_alu_if #(.WIDTH(16)) bus4 ();

    serial_alu #(.WIDTH(16), .DIGIT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    serial_alu #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: 16-bit two's-complement arithmetic straight from the op table.
    function automatic void ref_model(input logic [2:0] op_v, input logic [15:0] a,
                                      input logic [15:0] b, output logic [15:0] r,
                                      output logic c, output logic v, output logic z);
        int unsigned sum;
        c = 1'b0;
        v = 1'b0;
        case (op_v)
            3'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: begin
                sum = int'(a) + int'(b);
                r   = sum[15:0];
                c   = sum[16];
                v   = (a[15] == b[15]) && (r[15] != a[15]);
            end
        endcase
        z = (r == 16'h0000);
    endfunction

    // Start an op at the current negedge, follow it to done, check timing and results.
    // poke=1 raises start again mid-run; that request must be ignored.
    task automatic do_op(input logic [2:0] op_v, input logic [15:0] a, input logic [15:0] b,
                         input bit poke);
        logic [15:0] m_o;
        logic m_c, m_v, m_z;
        logic [15:0] o_start;
        int lat = 0;
        int busy_cnt = 0;
        bit moved = 1'b0;
        ref_model(op_v, a, b, m_o, m_c, m_v, m_z);
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.i0    = a;
        bus.i1    = b;
        o_start   = bus.o;
        repeat (64) begin
            @(negedge clk);
            lat++;
            bus.start = (poke && lat == 3);
            bus.op    = 3'($urandom);
            bus.i0    = 16'($urandom);
            bus.i1    = 16'($urandom);
            if (bus.busy) busy_cnt++;
            if (bus.done) break;
            if (bus.o !== o_start) moved = 1'b1;
        end
        check_eq("done_seen", bus.done, 1'b1);
        check_eq("latency", lat, 17);
        check_eq("busy_cycles", busy_cnt, 16);
        check_eq("o_stable_in_run", moved, 1'b0);
        check_eq("o", bus.o, m_o);
        check_eq("cout", bus.cout, m_c);
        check_eq("ovf", bus.ovf, m_v);
        check_eq("zero", bus.zero, m_z);
        bus.start = 1'b0;
    endtask

    // One idle cycle after done: pulse has ended and nothing was queued.
    task automatic idle_gap();
        @(negedge clk);
        check_eq("done_pulse_len", bus.done, 1'b0);
        check_eq("idle_busy", bus.busy, 1'b0);
    endtask

    task automatic do_op4(input logic [2:0] op_v, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] m_o;
        logic m_c, m_v, m_z;
        int lat = 0;
        int busy_cnt = 0;
        ref_model(op_v, a, b, m_o, m_c, m_v, m_z);
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.op    = op_v;
        bus4.i0    = a;
        bus4.i1    = b;
        repeat (32) begin
            @(negedge clk);
            lat++;
            bus4.start = 1'b0;
            bus4.i0    = 16'($urandom);
            bus4.i1    = 16'($urandom);
            if (bus4.busy) busy_cnt++;
            if (bus4.done) break;
        end
        check_eq("d4_done_seen", bus4.done, 1'b1);
        check_eq("d4_latency", lat, 5);
        check_eq("d4_busy_cycles", busy_cnt, 4);
        check_eq("d4_o", bus4.o, m_o);
        check_eq("d4_cout", bus4.cout, m_c);
        check_eq("d4_ovf", bus4.ovf, m_v);
        check_eq("d4_zero", bus4.zero, m_z);
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.i0     = 16'h0000;
        bus.i1     = 16'h0000;
        bus4.start = 1'b0;
        bus4.op    = 3'd0;
        bus4.i0    = 16'h0000;
        bus4.i1    = 16'h0000;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_o", bus.o, 16'h0000);
        check_eq("rst_cout", bus.cout, 1'b0);
        check_eq("rst_ovf", bus.ovf, 1'b0);
        check_eq("rst_zero", bus.zero, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_op(3'd0, 16'h1234, 16'h0FF1, 1'b0); idle_gap();
        check_eq("add_o_const", bus.o, 16'h2225);
        do_op(3'd1, 16'h0005, 16'h0007, 1'b0); idle_gap();
        check_eq("sub_o_const", bus.o, 16'hFFFE);
        do_op(3'd1, 16'h7FFF, 16'h7FFF, 1'b0); idle_gap();
        do_op(3'd0, 16'h7FFF, 16'h0001, 1'b0); idle_gap();
        check_eq("ovf_const", bus.ovf, 1'b1);
        do_op(3'd0, 16'hFFFF, 16'h0001, 1'b0); idle_gap();
        do_op(3'd2, 16'hF0F0, 16'h3C3C, 1'b0); idle_gap();
        do_op(3'd3, 16'hF0F0, 16'h3C3C, 1'b0); idle_gap();
        do_op(3'd4, 16'hF0F0, 16'h3C3C, 1'b0); idle_gap();
        check_eq("xor_o_const", bus.o, 16'hCCCC);
        do_op(3'd6, 16'h0100, 16'h0023, 1'b0); idle_gap();

        // Start during RUN is ignored; start during DONE is accepted.
        do_op(3'd0, 16'h1111, 16'h2222, 1'b1); idle_gap();
        do_op(3'd1, 16'h8000, 16'h0001, 1'b0);
        do_op(3'd0, 16'hFFFF, 16'h0002, 1'b0); idle_gap();

        // Reset at the 5th RUN cycle, with start held high on the reset edge.
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.i0    = 16'h4321;
        bus.i1    = 16'h1111;
        repeat (5) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check_eq("pre_rst_busy", bus.busy, 1'b1);
        rst_n     = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_busy", bus.busy, 1'b0);
        check_eq("mid_rst_done", bus.done, 1'b0);
        check_eq("mid_rst_o", bus.o, 16'h0000);
        check_eq("mid_rst_cout", bus.cout, 1'b0);
        check_eq("mid_rst_ovf", bus.ovf, 1'b0);
        check_eq("mid_rst_zero", bus.zero, 1'b0);
        rst_n = 1'b1;
        do_op(3'd0, 16'h4321, 16'h1111, 1'b0); idle_gap();

        // Randomized ops, sometimes chained back-to-back from DONE.
        for (int k = 0; k < 40; k++) begin
            do_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 0) idle_gap();
        end
        idle_gap();

        // DIGIT=4 instance.
        do_op4(3'd0, 16'h1234, 16'h0FF1);
        check_eq("d4_add_o_const", bus4.o, 16'h2225);
        do_op4(3'd1, 16'h7FFF, 16'h7FFF);
        do_op4(3'd0, 16'h7FFF, 16'h0001);
        for (int k = 0; k < 10; k++) begin
            do_op4(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
